wb_sequencer: RTL and testbench
===============================

# wb_sequencer

Write-back sequencer for the multi-cycle RISC datapath. It accepts one decoded write-back operation at a time from the decode stage and drives the Bus D source select and the register-file write strobe and address. For loads it runs a request/acknowledge handshake with data memory and enforces a timeout. It owns the Bus D mux select so that no register write ever samples an unsettled source.

## Interface
Parameters:
- DA_W, 5, register-file destination address width
- TIMEOUT, 15, maximum MEM_WAIT cycles before abort (2..255)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode presents an operation
- issue_ready  out  1  sequencer can accept; transfer when valid && ready
- issue_md  in  2  Bus D source: 00 F (ALU), 01 memory data_out, 11 {31'b0, N^V}; 10 illegal
- issue_da  in  DA_W  destination register
- issue_rw  in  1  register write requested
- mem_req  out  1  data-memory read request, level, held until ack
- mem_ack  in  1  memory data_out valid this cycle
- md_sel  out  2  Bus D mux select
- rf_we  out  1  register-file write strobe, one cycle per op
- rf_da  out  DA_W  register-file write address
- err_clr  in  1  clears sticky error flags
- err_timeout  out  1  sticky, a load timed out
- err_illegal  out  1  sticky, md = 10 was issued

## Operation
- States: IDLE, MEM_WAIT, WRITE. Reset → IDLE.
- issue_ready = 1 in IDLE and WRITE, 0 in MEM_WAIT. It is combinational from state only and never depends on issue_valid.
- On accept, md/da/rw are latched. md_sel and rf_da are driven from the latched values, so they are stable for the whole operation.
- Accepted md = 00 or 11:
  - rw = 1 → WRITE.
  - rw = 0 → op retires with no write; next state IDLE.
- Accepted md = 01 → MEM_WAIT; mem_req = 1 from the next cycle.
- Accepted md = 10 → err_illegal set, no write, latched md_sel not updated, next state IDLE.
- MEM_WAIT:
  - The wait counter increments each cycle.
  - If mem_ack = 1 → WRITE, and mem_req drops on the same edge.
  - Else, if counter = TIMEOUT−1 → err_timeout set, mem_req drops, IDLE, no write.
  - ack and timeout in the same cycle: ack wins.
- WRITE:
  - rf_we = latched rw for exactly one cycle; md_sel remains selected.
  - The WRITE exit state is chosen by the same rules as IDLE, so a new op can be accepted in WRITE (back-to-back).
  - No accept in WRITE → IDLE.
- Sticky errors: err_clr clears both flags. If a set and a clear occur in the same cycle, the set wins.
- Reset mid-operation: state, mem_req and rf_we clear immediately (asynchronously). An in-flight load is abandoned, and any late mem_ack is ignored in IDLE.

## Timing
- All outputs except issue_ready are registered.
- Reset values: mem_req 0, md_sel 00, rf_we 0, rf_da 0, err_timeout 0, err_illegal 0, state IDLE. issue_ready is therefore 1 out of reset.
- ALU/SLT latency: accept at edge k → rf_we = 1 in cycle k+1.
- Back-to-back ALU ops sustain one write per cycle.
- Load latency: accept at edge k → mem_req high from k+1. With mem_ack sampled at edge m, rf_we = 1 in cycle m+1 with md_sel = 01.
- Minimum load latency is 2 cycles (ack in the first MEM_WAIT cycle).
- Timeout: with no ack, mem_req is high for exactly TIMEOUT cycles, and err_timeout rises the cycle after.
- mem_ack outside MEM_WAIT is ignored.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - MD_F = 2'b00, MD_MEM = 2'b01, MD_SLT = 2'b11;
  - the wb state enum;
  - DA_W default.
- Both the MUX_D select encoding and the sequencer import these constants; no literal select codes appear in either block.
- One sub-module, wb_timeout_counter:
  - function: clear on enter, increment in MEM_WAIT, expire flag at TIMEOUT−1;
  - width: $clog2(TIMEOUT).
- The FSM and latches live in wb_sequencer.

## Test plan
- Reset, then ALU op (md 00, da 7, rw 1) → rf_we = 1, rf_da = 7, md_sel = 00 one cycle after accept; issue_ready stays 1.
- Three back-to-back SLT ops to da 1, 2, 3 → rf_we high 3 consecutive cycles with rf_da 1, 2, 3 and md_sel = 11.
- Load to da 4, ack after 3 MEM_WAIT cycles → issue_ready = 0 for 3 cycles; mem_req high 3 cycles; rf_we = 1 with md_sel = 01 and rf_da = 4 on the next cycle.
- Load with no ack, TIMEOUT = 4 → mem_req high exactly 4 cycles; err_timeout = 1; no rf_we. Then err_clr → 0. Then ack and timeout coincident → write occurs, no error.
- md = 10 issued → err_illegal = 1; no rf_we; md_sel unchanged. err_clr asserted in the same cycle as a new md = 10 → flag stays 1.
- rst_n pulsed low during MEM_WAIT, then a late mem_ack → mem_req 0 immediately, state IDLE, no rf_we, no error.

Source files
------------

// File: rtl/wb_sequencer_pkg.sv
// rtl/wb_sequencer_pkg.sv - shared control constants for the write-back path
package cpu_ctrl_pkg;

  // Bus D source select encoding, shared by MUX_D and the sequencer
  localparam logic [1:0] MD_F   = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_ILL = 2'b10;
  localparam logic [1:0] MD_SLT = 2'b11;

  // Default register-file destination address width
  localparam int DA_W_DEF = 5;

  // Write-back sequencer states
  typedef enum logic [1:0] {
    WB_IDLE     = 2'd0,
    WB_MEM_WAIT = 2'd1,
    WB_WRITE    = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_sequencer_if.sv
// rtl/wb_sequencer_if.sv - issue, memory handshake, register-file and error signals
interface wb_sequencer_if
  import cpu_ctrl_pkg::*;
#(
  parameter int DA_W = DA_W_DEF
);

  logic            issue_valid;
  logic            issue_ready;
  logic [1:0]      issue_md;
  logic [DA_W-1:0] issue_da;
  logic            issue_rw;
  logic            mem_req;
  logic            mem_ack;
  logic [1:0]      md_sel;
  logic            rf_we;
  logic [DA_W-1:0] rf_da;
  logic            err_clr;
  logic            err_timeout;
  logic            err_illegal;

  // Environment side: decode stage, data memory and error clearing
  modport master (
    output issue_valid, issue_md, issue_da, issue_rw, mem_ack, err_clr,
    input  issue_ready, mem_req, md_sel, rf_we, rf_da, err_timeout, err_illegal
  );

  // Sequencer side
  modport slave (
    input  issue_valid, issue_md, issue_da, issue_rw, mem_ack, err_clr,
    output issue_ready, mem_req, md_sel, rf_we, rf_da, err_timeout, err_illegal
  );

endinterface

// File: rtl/wb_sequencer_timeout_counter.sv
// rtl/wb_sequencer_timeout_counter.sv - load wait counter with expiry flag
module wb_timeout_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count wait cycles; clear takes priority so a new load always starts from zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/wb_sequencer.sv
// rtl/wb_sequencer.sv - write-back sequencer: Bus D select, register write strobe, load handshake
module wb_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DA_W    = DA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  wb_sequencer_if.slave  bus
);

  wb_state_e       r_state;
  wb_state_e       w_state_nxt;
  logic [1:0]      r_md_sel;
  logic [1:0]      w_md_nxt;
  logic [DA_W-1:0] r_rf_da;
  logic [DA_W-1:0] w_da_nxt;
  logic            r_rw;
  logic            w_rw_nxt;
  logic            r_mem_req;
  logic            w_mem_req_nxt;
  logic            r_rf_we;
  logic            w_rf_we_nxt;
  logic            r_err_timeout;
  logic            r_err_illegal;
  logic            w_set_timeout;
  logic            w_set_illegal;
  logic            w_cnt_clr;
  logic            w_cnt_en;
  logic            w_expire;
  logic            w_issue_ready;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_expire (w_expire)
  );

  // Next-state and next-output decode; IDLE and WRITE share the accept rules
  always_comb begin
    w_state_nxt   = r_state;
    w_md_nxt      = r_md_sel;
    w_da_nxt      = r_rf_da;
    w_rw_nxt      = r_rw;
    w_mem_req_nxt = 1'b0;
    w_rf_we_nxt   = 1'b0;
    w_set_timeout = 1'b0;
    w_set_illegal = 1'b0;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;
    w_issue_ready = 1'b0;
    case (r_state)
      WB_IDLE, WB_WRITE: begin
        w_issue_ready = 1'b1;
        w_state_nxt   = WB_IDLE;
        if (bus.issue_valid) begin
          if (bus.issue_md == MD_ILL) begin
            // Illegal select: flag it and leave the latched select untouched
            w_set_illegal = 1'b1;
          end else begin
            w_md_nxt = bus.issue_md;
            w_da_nxt = bus.issue_da;
            w_rw_nxt = bus.issue_rw;
            if (bus.issue_md == MD_MEM) begin
              w_state_nxt   = WB_MEM_WAIT;
              w_mem_req_nxt = 1'b1;
              w_cnt_clr     = 1'b1;
            end else if (bus.issue_rw) begin
              w_state_nxt = WB_WRITE;
              w_rf_we_nxt = 1'b1;
            end
          end
        end
      end
      WB_MEM_WAIT: begin
        w_cnt_en = 1'b1;
        if (bus.mem_ack) begin
          // Ack is checked first so a coincident ack beats the timeout
          w_state_nxt = WB_WRITE;
          w_rf_we_nxt = r_rw;
        end else if (w_expire) begin
          w_state_nxt   = WB_IDLE;
          w_set_timeout = 1'b1;
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = WB_IDLE;
      end
    endcase
  end

  // State, latched operation fields and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= WB_IDLE;
      r_md_sel  <= MD_F;
      r_rf_da   <= '0;
      r_rw      <= 1'b0;
      r_mem_req <= 1'b0;
      r_rf_we   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_md_sel  <= w_md_nxt;
      r_rf_da   <= w_da_nxt;
      r_rw      <= w_rw_nxt;
      r_mem_req <= w_mem_req_nxt;
      r_rf_we   <= w_rf_we_nxt;
    end
  end

  // Sticky error flags; a set in the same cycle as a clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_timeout <= 1'b0;
      r_err_illegal <= 1'b0;
    end else begin
      r_err_timeout <= w_set_timeout | (r_err_timeout & ~bus.err_clr);
      r_err_illegal <= w_set_illegal | (r_err_illegal & ~bus.err_clr);
    end
  end

  assign bus.issue_ready = w_issue_ready;
  assign bus.mem_req     = r_mem_req;
  assign bus.md_sel      = r_md_sel;
  assign bus.rf_we       = r_rf_we;
  assign bus.rf_da       = r_rf_da;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_illegal = r_err_illegal;

endmodule

// File: tb/tb_wb_sequencer.sv
// tb/tb_wb_sequencer.sv - directed self-checking bench for wb_sequencer
module tb_wb_sequencer;
  import cpu_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   n_req;
  int   n_we;

  wb_sequencer_if #(.DA_W(5)) bus_if ();

  wb_sequencer #(
    .DA_W    (5),
    .TIMEOUT (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] md, input logic [4:0] da, input logic rw);
    bus_if.issue_valid = 1'b1;
    bus_if.issue_md    = md;
    bus_if.issue_da    = da;
    bus_if.issue_rw    = rw;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_if.issue_valid = 1'b0;
    bus_if.issue_md    = 2'b00;
    bus_if.issue_da    = 5'd0;
    bus_if.issue_rw    = 1'b0;
    bus_if.mem_ack     = 1'b0;
    bus_if.err_clr     = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_mem_req", bus_if.mem_req, 0);
    check("rst_md_sel", bus_if.md_sel, 0);
    check("rst_rf_we", bus_if.rf_we, 0);
    check("rst_rf_da", bus_if.rf_da, 0);
    check("rst_err_to", bus_if.err_timeout, 0);
    check("rst_err_ill", bus_if.err_illegal, 0);
    check("rst_ready", bus_if.issue_ready, 1);
    rst_n = 1'b1;
    tick();

    // ALU op md 00 da 7 rw 1
    issue(MD_F, 5'd7, 1'b1);
    tick();
    bus_if.issue_valid = 1'b0;
    check("alu_we", bus_if.rf_we, 1);
    check("alu_da", bus_if.rf_da, 7);
    check("alu_md", bus_if.md_sel, 0);
    check("alu_ready", bus_if.issue_ready, 1);
    tick();
    check("alu_we_drop", bus_if.rf_we, 0);

    // three back-to-back SLT ops
    for (int i = 1; i <= 3; i++) begin
      issue(MD_SLT, 5'(i), 1'b1);
      tick();
      check("slt_we", bus_if.rf_we, 1);
      check("slt_da", bus_if.rf_da, i);
      check("slt_md", bus_if.md_sel, 3);
    end
    bus_if.issue_valid = 1'b0;
    tick();
    check("slt_we_drop", bus_if.rf_we, 0);

    // ALU op with rw=0 retires without a write
    issue(MD_F, 5'd8, 1'b0);
    tick();
    bus_if.issue_valid = 1'b0;
    check("norw_we", bus_if.rf_we, 0);
    check("norw_ready", bus_if.issue_ready, 1);

    // load to da 4, ack in the third MEM_WAIT cycle
    issue(MD_MEM, 5'd4, 1'b1);
    tick();
    bus_if.issue_valid = 1'b0;
    n_req = 0;
    for (int c = 1; c <= 3; c++) begin
      if (bus_if.mem_req) n_req++;
      check("ld_ready_low", bus_if.issue_ready, 0);
      check("ld_no_we", bus_if.rf_we, 0);
      if (c == 3) bus_if.mem_ack = 1'b1;
      tick();
    end
    bus_if.mem_ack = 1'b0;
    check("ld_req_cycles", n_req, 3);
    check("ld_req_drop", bus_if.mem_req, 0);
    check("ld_we", bus_if.rf_we, 1);
    check("ld_md", bus_if.md_sel, 1);
    check("ld_da", bus_if.rf_da, 4);
    tick();
    check("ld_we_drop", bus_if.rf_we, 0);

    // load with no ack: TIMEOUT=4
    issue(MD_MEM, 5'd5, 1'b1);
    tick();
    bus_if.issue_valid = 1'b0;
    n_req = 0;
    n_we  = 0;
    while (bus_if.mem_req && n_req < 20) begin
      n_req++;
      if (bus_if.rf_we) n_we++;
      check("to_err_early", bus_if.err_timeout, 0);
      tick();
    end
    check("to_req_cycles", n_req, 4);
    check("to_err", bus_if.err_timeout, 1);
    check("to_no_we", n_we + int'(bus_if.rf_we), 0);
    check("to_ready", bus_if.issue_ready, 1);
    bus_if.err_clr = 1'b1;
    tick();
    bus_if.err_clr = 1'b0;
    check("to_clr", bus_if.err_timeout, 0);

    // ack coincident with timeout: ack in the fourth wait cycle
    issue(MD_MEM, 5'd6, 1'b1);
    tick();
    bus_if.issue_valid = 1'b0;
    tick();
    tick();
    tick();
    check("co_req", bus_if.mem_req, 1);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check("co_we", bus_if.rf_we, 1);
    check("co_da", bus_if.rf_da, 6);
    check("co_md", bus_if.md_sel, 1);
    check("co_err", bus_if.err_timeout, 0);
    check("co_req_drop", bus_if.mem_req, 0);
    tick();

    // illegal md = 10
    issue(MD_ILL, 5'd9, 1'b1);
    tick();
    bus_if.issue_valid = 1'b0;
    check("ill_err", bus_if.err_illegal, 1);
    check("ill_no_we", bus_if.rf_we, 0);
    check("ill_md_keep", bus_if.md_sel, 1);
    check("ill_da_keep", bus_if.rf_da, 6);
    check("ill_ready", bus_if.issue_ready, 1);
    issue(MD_ILL, 5'd9, 1'b1);
    bus_if.err_clr = 1'b1;
    tick();
    bus_if.issue_valid = 1'b0;
    check("ill_set_wins", bus_if.err_illegal, 1);
    tick();
    bus_if.err_clr = 1'b0;
    check("ill_clr", bus_if.err_illegal, 0);

    // reset pulse during MEM_WAIT, then a late ack
    issue(MD_MEM, 5'd10, 1'b1);
    tick();
    bus_if.issue_valid = 1'b0;
    tick();
    check("rm_req_before", bus_if.mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rm_req_async", bus_if.mem_req, 0);
    check("rm_ready_async", bus_if.issue_ready, 1);
    check("rm_we_async", bus_if.rf_we, 0);
    tick();
    rst_n = 1'b1;
    bus_if.mem_ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rm_late_we", bus_if.rf_we, 0);
      check("rm_late_req", bus_if.mem_req, 0);
      check("rm_late_err", {bus_if.err_timeout, bus_if.err_illegal}, 0);
      check("rm_late_ready", bus_if.issue_ready, 1);
    end
    bus_if.mem_ack = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
